// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch (if) and memory (dm) stages.
// Build option MEMARB_RR_EN selects round-robin tie breaking; otherwise dm has fixed priority over if.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    // fetch stage port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    // memory stage port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    // pipeline stalls
    output logic              stall_f,
    output logic              stall_m,
    // memory bus
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // debug view of the arbiter FSM: 0 = IDLE, 1 = BUSY_IF, 2 = BUSY_DM
    output logic [1:0]        fsm_state
);

    // Handshake: a requester raises x_req with stable fields and holds them until the
    // one-cycle x_valid pulse; the bus holds mem_req with frozen fields until the
    // one-cycle mem_ack, which completes the transaction in that same cycle.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t state;
    logic   drop;
    logic   ack_if;
    logic   ack_dm;
    logic   grant_if;
    logic   grant_dm;
`ifdef MEMARB_RR_EN
    logic   rr_last_dm;
`endif

    assign ack_if    = (state == BUSY_IF) && mem_ack;
    assign ack_dm    = (state == BUSY_DM) && mem_ack;
    assign stall_f   = if_req && !if_valid;
    assign stall_m   = dm_req && !dm_valid;
    assign fsm_state = state;

    // Arbitration happens in IDLE and on an ack cycle; the port just served sits out.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        case (state)
            IDLE: begin
`ifdef MEMARB_RR_EN
                if (if_req && dm_req) begin
                    grant_dm = !rr_last_dm;
                    grant_if = rr_last_dm;
                end else begin
                    grant_dm = dm_req;
                    grant_if = if_req;
                end
`else
                grant_dm = dm_req;
                grant_if = if_req && !dm_req;
`endif
            end
            BUSY_IF: grant_dm = mem_ack && dm_req;
            BUSY_DM: grant_if = mem_ack && if_req;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_valid  <= 1'b0;
            dm_rdata  <= '0;
            drop      <= 1'b0;
`ifdef MEMARB_RR_EN
            rr_last_dm <= 1'b0;
`endif
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            // A cancel seen in the ack cycle itself still kills the response.
            if (ack_if && !(drop || if_cancel)) begin
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
            end
            if (ack_dm) begin
                dm_valid <= 1'b1;
                dm_rdata <= mem_we ? '0 : mem_rdata;
            end

            if (grant_dm) begin
                state     <= BUSY_DM;
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                state     <= BUSY_IF;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (ack_if || ack_dm) begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end

            // The drop flag covers the fetch from its grant cycle through its ack cycle.
            if (grant_if) begin
                drop <= if_cancel;
            end else if (ack_if) begin
                drop <= 1'b0;
            end else if (state == BUSY_IF) begin
                drop <= drop || if_cancel;
            end

`ifdef MEMARB_RR_EN
            if (grant_dm) begin
                rr_last_dm <= 1'b1;
            end else if (grant_if) begin
                rr_last_dm <= 1'b0;
            end
`endif
        end
    end

    // Bus fields must stay frozen while a transaction waits for its ack.
    a_bus_frozen: assert property (@(posedge clock) disable iff (!reset_n)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_we) && $stable(mem_addr) && $stable(mem_wdata)));

    a_one_valid: assert property (@(posedge clock) disable iff (!reset_n)
        !(if_valid && dm_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, tie/cancel/reset sequences and a randomized
// run checked against a transaction-level model of the arbiter (honours MEMARB_RR_EN).
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          if_req, if_cancel, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_valid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          stall_f, stall_m;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    fsm_state;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        if_req    = 1'b0; if_addr = '0; if_cancel = 1'b0;
        dm_req    = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ack   = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          cancel_at;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        logic act_v, oth_v, act_s;
        logic [31:0] act_d;
        dm_we = v.we; dm_wdata = v.wdata;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_addr = v.addr;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        mem_ack = 1'b0; if_cancel = 1'b0;
        @(negedge clock);
        act_s = v.is_dm ? stall_m : stall_f;
        check($sformatf("v%0d_arb_mem_req", idx), mem_req, 0);
        check($sformatf("v%0d_arb_stall", idx), act_s, 1);
        next_cycle();
        for (int i = 0; i <= v.lat; i++) begin
            mem_ack   = (i == v.lat);
            mem_rdata = (i == v.lat) ? v.rdata : $urandom();
            if_cancel = (i == v.cancel_at);
            @(negedge clock);
            act_s = v.is_dm ? stall_m : stall_f;
            act_v = v.is_dm ? dm_valid : if_valid;
            check($sformatf("v%0d_c%0d_mem_req", idx, i), mem_req, 1);
            check($sformatf("v%0d_c%0d_mem_we", idx, i), mem_we, v.exp_we);
            check($sformatf("v%0d_c%0d_mem_addr", idx, i), mem_addr, v.addr);
            check($sformatf("v%0d_c%0d_mem_wdata", idx, i), mem_wdata, v.exp_wdata);
            check($sformatf("v%0d_c%0d_stall", idx, i), act_s, 1);
            check($sformatf("v%0d_c%0d_early_valid", idx, i), act_v, 0);
            next_cycle();
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0; if_cancel = 1'b0;
        @(negedge clock);
        act_v = v.is_dm ? dm_valid : if_valid;
        oth_v = v.is_dm ? if_valid : dm_valid;
        act_d = v.is_dm ? dm_rdata : if_rdata;
        check($sformatf("v%0d_valid", idx), act_v, v.exp_valid);
        check($sformatf("v%0d_rdata", idx), act_d, v.exp_rdata);
        check($sformatf("v%0d_other_valid", idx), oth_v, 0);
        check($sformatf("v%0d_post_mem_req", idx), mem_req, 0);
        next_cycle();
        @(negedge clock);
        act_v = v.is_dm ? dm_valid : if_valid;
        check($sformatf("v%0d_valid_one_cycle", idx), act_v, 0);
        next_cycle();
    endtask

    // ---------------- reference model + scoreboard ----------------
    // m_owner: 0 = bus free, 1 = fetch transaction, 2 = data transaction
    int          m_owner;
    logic        m_we, m_drop;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
`ifdef MEMARB_RR_EN
    logic        m_last_dm;
`endif
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] dm_exp_q[$];
    int            lat_left;

    task automatic model_reset();
        m_owner = 0; m_we = 1'b0; m_drop = 1'b0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
`ifdef MEMARB_RR_EN
        m_last_dm = 1'b0;
`endif
        if_exp_q.delete();
        dm_exp_q.delete();
        lat_left = -1;
    endtask

    // Advances the model across one rising edge using the inputs held this cycle.
    task automatic model_step();
        int   served;
        logic want_if, want_dm, pick_dm;
        served = (m_owner != 0 && mem_ack) ? m_owner : 0;
        if (served == 1) begin
            if (!(m_drop || if_cancel)) if_exp_q.push_back(mem_rdata);
            m_drop = 1'b0;
        end else if (served == 2) begin
            dm_exp_q.push_back(m_we ? 32'h0 : mem_rdata);
        end else if (m_owner == 1) begin
            m_drop = m_drop || if_cancel;
        end
        if (m_owner == 0 || served != 0) begin
            want_if = if_req && (served != 1);
            want_dm = dm_req && (served != 2);
`ifdef MEMARB_RR_EN
            pick_dm = (want_if && want_dm) ? !m_last_dm : want_dm;
`else
            pick_dm = want_dm;
`endif
            if (pick_dm) begin
                m_owner = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
`ifdef MEMARB_RR_EN
                m_last_dm = 1'b1;
`endif
            end else if (want_if) begin
                m_owner = 1; m_we = 1'b0; m_addr = if_addr; m_wdata = 32'h0;
                m_drop = if_cancel;
`ifdef MEMARB_RR_EN
                m_last_dm = 1'b0;
`endif
            end else begin
                m_owner = 0;
            end
        end
    endtask

    task automatic random_check(input int cyc);
        logic exp_if_v, exp_dm_v;
        exp_if_v = (if_exp_q.size() != 0);
        exp_dm_v = (dm_exp_q.size() != 0);
        check($sformatf("rnd%0d_if_valid", cyc), if_valid, exp_if_v);
        check($sformatf("rnd%0d_dm_valid", cyc), dm_valid, exp_dm_v);
        check($sformatf("rnd%0d_stall_f", cyc), stall_f, if_req && !exp_if_v);
        check($sformatf("rnd%0d_stall_m", cyc), stall_m, dm_req && !exp_dm_v);
        if (exp_if_v) m_if_rdata = if_exp_q.pop_front();
        if (exp_dm_v) m_dm_rdata = dm_exp_q.pop_front();
        check($sformatf("rnd%0d_if_rdata", cyc), if_rdata, m_if_rdata);
        check($sformatf("rnd%0d_dm_rdata", cyc), dm_rdata, m_dm_rdata);
        check($sformatf("rnd%0d_mem_req", cyc), mem_req, m_owner != 0);
        if (m_owner != 0) begin
            check($sformatf("rnd%0d_mem_we", cyc), mem_we, m_we);
            check($sformatf("rnd%0d_mem_addr", cyc), mem_addr, m_addr);
            check($sformatf("rnd%0d_mem_wdata", cyc), mem_wdata, m_wdata);
        end
    endtask

    // Requesters and memory responder; DUT outputs only steer protocol, never expectations.
    task automatic drive_random();
        if (if_req && if_valid) begin
            if ($urandom_range(1, 0) == 1) if_req = 1'b0;
            else if_addr = $urandom() & 32'hFFFF_FFFC;
        end else if (!if_req && $urandom_range(99, 0) < 30) begin
            if_req = 1'b1; if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (dm_req && dm_valid) begin
            if ($urandom_range(1, 0) == 1) dm_req = 1'b0;
            else begin
                dm_addr = $urandom() & 32'hFFFF_FFFC; dm_we = ($urandom_range(1, 0) == 1); dm_wdata = $urandom();
            end
        end else if (!dm_req && $urandom_range(99, 0) < 30) begin
            dm_req = 1'b1; dm_addr = $urandom() & 32'hFFFF_FFFC;
            dm_we = ($urandom_range(1, 0) == 1); dm_wdata = $urandom();
        end
        if_cancel = ($urandom_range(99, 0) < 8);
        mem_rdata = $urandom();
        if (mem_req) begin
            if (lat_left < 0) lat_left = $urandom_range(3, 0);
            if (lat_left == 0) begin
                mem_ack = 1'b1; lat_left = -1;
            end else begin
                mem_ack = 1'b0; lat_left--;
            end
        end else begin
            mem_ack = ($urandom_range(9, 0) == 0);
            lat_left = -1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic exp_dm_first;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0050_0093, 2, -1, 1'b1, 32'h0050_0093, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0BAD_F00D, 32'h1234_5678, 0, -1, 1'b1, 32'h1234_5678, 1'b0, 32'h0BAD_F00D};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, -1, 1'b1, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0104, 32'h5555_5555, 32'h1111_1111, 3, 1, 1'b0, 32'h0050_0093, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'hABCD_0001, 1, -1, 1'b1, 32'hABCD_0001, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0204, 32'h6666_6666, 32'h2222_2222, 0, 0, 1'b0, 32'hABCD_0001, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 3, -1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0044, 32'h0102_0304, 32'h7777_7777, 0, -1, 1'b1, 32'h0, 1'b1, 32'h0102_0304};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h3333_3333, 2, 2, 1'b0, 32'hABCD_0001, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 32'h0000_0304, 32'h0, 32'h0000_0013, 0, -1, 1'b1, 32'h0000_0013, 1'b0, 32'h0};

        // reset values
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_state", fsm_state, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_dm_valid", dm_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        reset_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // simultaneous requests, zero-latency acks: back-to-back with no mem_req gap
        if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_wdata = 32'h0;
        mem_ack = 1'b0;
        @(negedge clock);
        check("tie_arb_mem_req", mem_req, 0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'hD0D0_D0D0;
        @(negedge clock);
        check("tie_g1_mem_req", mem_req, 1);
        check("tie_g1_mem_addr", mem_addr, 32'h2000);
        check("tie_g1_mem_we", mem_we, 0);
        next_cycle();
        dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1F1F_1F1F;
        @(negedge clock);
        check("tie_g2_mem_req_no_gap", mem_req, 1);
        check("tie_g2_mem_addr", mem_addr, 32'h100);
        check("tie_g2_dm_valid", dm_valid, 1);
        check("tie_g2_dm_rdata", dm_rdata, 32'hD0D0_D0D0);
        check("tie_g2_if_valid", if_valid, 0);
        next_cycle();
        if_req = 1'b0; mem_ack = 1'b0;
        @(negedge clock);
        check("tie_g3_if_valid", if_valid, 1);
        check("tie_g3_if_rdata", if_rdata, 32'h1F1F_1F1F);
        check("tie_g3_mem_req", mem_req, 0);
        next_cycle();

        // repeated isolated ties: fixed priority always picks dm, round-robin alternates
        for (int r = 0; r < 2; r++) begin
`ifdef MEMARB_RR_EN
            exp_dm_first = (r == 0);
`else
            exp_dm_first = 1'b1;
`endif
            if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
            mem_ack = 1'b0;
            @(negedge clock);
            next_cycle();
            if (exp_dm_first) if_req = 1'b0; else dm_req = 1'b0;
            mem_ack = 1'b1; mem_rdata = 32'h5A00_0000 + r;
            @(negedge clock);
            check($sformatf("rr%0d_winner_addr", r), mem_addr, exp_dm_first ? 32'h2000 : 32'h100);
            next_cycle();
            if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
            @(negedge clock);
            check($sformatf("rr%0d_dm_valid", r), dm_valid, exp_dm_first);
            check($sformatf("rr%0d_if_valid", r), if_valid, !exp_dm_first);
            check($sformatf("rr%0d_mem_req", r), mem_req, 0);
            next_cycle();
        end

        // mem_ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge clock);
        check("idle_ack_mem_req", mem_req, 0);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clock);
        check("idle_ack_state", fsm_state, 0);
        check("idle_ack_if_valid", if_valid, 0);
        check("idle_ack_dm_valid", dm_valid, 0);
        check("idle_ack_mem_req", mem_req, 0);
        next_cycle();

        // reset in the middle of a data transaction
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2468;
        @(negedge clock);
        next_cycle();
        @(negedge clock);
        check("mid_rst_busy_state", fsm_state, 2);
        check("mid_rst_busy_mem_req", mem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_dm_valid", dm_valid, 0);
        check("mid_rst_if_valid", if_valid, 0);
        check("mid_rst_state", fsm_state, 0);
        dm_req = 1'b0; mem_ack = 1'b1;
        repeat (2) @(posedge clock);
        mem_ack = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle();
        @(negedge clock);
        check("post_rst_state", fsm_state, 0);
        check("post_rst_mem_req", mem_req, 0);
        check("post_rst_dm_valid", dm_valid, 0);
        next_cycle();

        // randomized traffic against the model
        apply_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            @(negedge clock);
            random_check(c);
            model_step();
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage core. It arbitrates requests, holds the memory bus for variable-latency transactions and returns registered responses. It also drives per-stage stall signals and discards responses for fetches cancelled by a taken branch or jump redirect. It sits between the pipeline's F/M stages and the external memory model, replacing the separate IMEM/DMEM ports.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- clock  in  1  single clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with stable if_addr until if_valid
- if_addr  in  ADDR_W  fetch address
- if_cancel  in  1  redirect (pc_sel); kills the in-flight fetch response
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request; held with stable fields until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_valid  out  1  one-cycle pulse; load data valid or store done
- dm_rdata  out  DATA_W  load data (0 for stores)
- stall_f  out  1  if_req && !if_valid
- stall_m  out  1  dm_req && !dm_valid
- mem_req  out  1  memory bus request; held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  one-cycle completion; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE: if any request is pending, grant a winner and register the mem_* fields from it, then go to BUSY_<winner>. A fetch grant forces mem_we = 0 and mem_wdata = 0.
- Priority (default): dm wins over if.
- BUSY_x: mem_req = 1, and mem_* fields stay frozen until mem_ack. On mem_ack:
  - capture mem_rdata into x_rdata and pulse x_valid next cycle.
  - The served requester is excluded from this cycle's arbitration. If the other requester is pending, grant it and go to BUSY_other, so mem_req stays high with the new fields. Otherwise go to IDLE.
- Cancel: if_cancel high in any cycle from the fetch grant through its mem_ack cycle sets a drop flag. When that fetch is acked, if_valid is suppressed and if_rdata is left unchanged. The flag clears on that ack. if_cancel while the fetch is not granted, or in the if_valid cycle, has no effect.
- For stores, dm_rdata = 0.
- mem_ack in IDLE is ignored.
- stall_f and stall_m are combinational.

## Timing
- Reset values: state IDLE; mem_req, mem_we, if_valid, dm_valid = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; drop flag and RR pointer = 0.
- Reset mid-transaction aborts immediately: mem_req drops asynchronously and no valid pulse is issued.
- Latency: req sampled at edge t → mem_req high from t+1. If mem_ack arrives at cycle t+1+k (k ≥ 0), x_valid pulses at t+2+k. Minimum request-to-valid latency is 2 edges.
- Back-to-back: on an ack cycle with the other requester pending, mem_req has no low cycle.
- A requester still asserting req in its valid cycle is treated as a new request at the next arbitration.
- Simultaneous if_req and dm_req in IDLE: resolved by the priority rule.
- Simultaneous if_cancel and mem_ack for the fetch: response dropped.

## Configuration
- MEMARB_RR_EN defined: round-robin arbitration. A 1-bit pointer records the last granted requester, and that requester loses ties at the next arbitration.
- MEMARB_RR_EN undefined: fixed priority, dm over if. No pointer flop.

## Test plan
- Fetch only, memory acks 2 cycles after mem_req, mem_rdata = 0x00500093 → if_valid for exactly one cycle with if_rdata = 0x00500093. stall_f is high from req until the valid cycle. mem_we = 0 throughout.
- Simultaneous if_req (0x100) and dm_req load (0x2000) with 0-cycle ack:
  - Default build: dm granted first, then if back-to-back with no mem_req gap.
  - MEMARB_RR_EN build: the tie order alternates on repeated ties.
- Store dm_addr 0x40, dm_wdata 0xDEADBEEF → mem_we = 1 and mem_addr/mem_wdata match until ack. dm_valid pulses with dm_rdata = 0.
- Fetch granted, if_cancel pulsed before mem_ack → no if_valid pulse. A following new fetch to 0x200 completes normally.
- Assert reset_n low while in BUSY_DM with mem_req = 1 → mem_req, dm_valid and if_valid are 0 immediately. After release, state is IDLE.
- mem_ack pulsed while IDLE → no valid pulse, no state change.
